// File: rtl/rumble_pkg.sv
// Shared types and helpers for the rumble controller.
// Holds the FSM state encoding, the strength codes and the PWM duty lookup.
// No ports; imported by rumble_debounce and rumble_ctrl.
package rumble_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ON       = 2'd1,
    HOLD     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [1:0] STR_OFF = 2'd0;
  localparam logic [1:0] STR_25  = 2'd1;
  localparam logic [1:0] STR_50  = 2'd2;
  localparam logic [1:0] STR_100 = 2'd3;

  // Number of 1/16 PWM steps per frame during which the motor is driven.
  function automatic logic [4:0] duty_threshold(input logic [1:0] strength);
    logic [4:0] thr;
    case (strength)
      STR_25:  thr = 5'd4;
      STR_50:  thr = 5'd8;
      STR_100: thr = 5'd16;
      default: thr = 5'd0;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/rumble_debounce.sv
// Motor request conditioner: 2-flop synchroniser followed by a tick-based stable filter.
// Ports: clk_74a, reset (sync, active-high), tick (1 ms strobe), motor_req (async raw) -> req_f.
// Latency: 2 cycles into req_s, then DEBOUNCE_MS consecutive differing ticks before req_f follows.
module rumble_debounce #(
  parameter int DEBOUNCE_MS = 2
) (
  input  logic clk_74a,
  input  logic reset,
  input  logic tick,
  input  logic motor_req,
  output logic req_f
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          req_m;
  logic          req_s;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      req_m      <= 1'b0;
      req_s      <= 1'b0;
      req_f      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      req_m <= motor_req;
      req_s <= req_m;
      // Any return to agreement restarts the count, so a bounce never accumulates.
      if (req_s == req_f) begin
        stable_cnt <= '0;
      end else if (tick) begin
        if (stable_cnt == CW'(DEBOUNCE_MS - 1)) begin
          req_f      <= req_s;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rumble_ctrl.sv
// Rumble motor policy: debounced request, min-on / max-on / cooldown FSM, strength PWM.
// Ports: clk_74a, reset, motor_req (async), enable, strength[1:0] -> active, busy, timeout.
// Latency: req_f rise to active rise is 2 cycles; enable/strength drop gates active in 0 cycles.
module rumble_ctrl
  import rumble_pkg::*;
#(
  parameter int PRESCALE    = 74250,
  parameter int DEBOUNCE_MS = 2,
  parameter int MIN_ON_MS   = 20,
  parameter int MAX_ON_MS   = 3000,
  parameter int COOLDOWN_MS = 500,
  parameter int PWM_DIV     = 4640
) (
  input  logic       clk_74a,
  input  logic       reset,
  input  logic       motor_req,
  input  logic       enable,
  input  logic [1:0] strength,
  output logic       active,
  output logic       busy,
  output logic       timeout
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int DW = $clog2(PWM_DIV + 1);
  localparam int OW = $clog2(MAX_ON_MS + 1);
  localparam int CW = $clog2(COOLDOWN_MS + 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [DW-1:0] div_cnt;
  logic [3:0]    pwm_pos;
  logic          pwm_on;
  logic          req_f;
  logic          gate;

  state_t        state, state_n;
  logic [OW-1:0] on_cnt, on_cnt_n, on_inc;
  logic [CW-1:0] cd_cnt, cd_cnt_n, cd_inc;
  logic          timeout_r, timeout_n;
  logic          active_r;
  logic          busy_r;

  assign tick   = (pre_cnt == PW'(PRESCALE - 1));
  assign gate   = enable & (strength != STR_OFF);
  assign pwm_on = ({1'b0, pwm_pos} < duty_threshold(strength)) | (strength == STR_100);
  assign on_inc = on_cnt + OW'(tick);
  assign cd_inc = cd_cnt + CW'(tick);

  rumble_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_debounce (
    .clk_74a  (clk_74a),
    .reset    (reset),
    .tick     (tick),
    .motor_req(motor_req),
    .req_f    (req_f)
  );

  // ms prescaler and free-running PWM position; neither is tied to FSM state.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      pre_cnt <= '0;
      div_cnt <= '0;
      pwm_pos <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (div_cnt == DW'(PWM_DIV - 1)) begin
        div_cnt <= '0;
        pwm_pos <= pwm_pos + 4'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_n   = state;
    on_cnt_n  = on_cnt;
    cd_cnt_n  = cd_cnt;
    timeout_n = timeout_r;
    if (!gate) begin
      state_n   = IDLE;
      on_cnt_n  = '0;
      cd_cnt_n  = '0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_f) begin
            state_n  = ON;
            on_cnt_n = '0;
          end
        end
        ON: begin
          on_cnt_n = on_inc;
          // Timeout is tested first so it beats a simultaneous request drop.
          if (on_inc == OW'(MAX_ON_MS)) begin
            state_n   = COOLDOWN;
            timeout_n = 1'b1;
            cd_cnt_n  = '0;
          end else if (!req_f && (on_inc >= OW'(MIN_ON_MS))) begin
            state_n = IDLE;
          end else if (!req_f) begin
            state_n = HOLD;
          end
        end
        HOLD: begin
          on_cnt_n = on_inc;
          if (on_inc >= OW'(MIN_ON_MS)) begin
            state_n = IDLE;
          end else if (req_f) begin
            state_n = ON;
          end
        end
        COOLDOWN: begin
          cd_cnt_n = cd_inc;
          if (cd_inc == CW'(COOLDOWN_MS)) begin
            state_n  = IDLE;
            cd_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state     <= IDLE;
      on_cnt    <= '0;
      cd_cnt    <= '0;
      timeout_r <= 1'b0;
      active_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_n;
      on_cnt    <= on_cnt_n;
      cd_cnt    <= cd_cnt_n;
      timeout_r <= timeout_n;
      active_r  <= ((state == ON) || (state == HOLD)) & pwm_on & gate;
      busy_r    <= (state == ON) || (state == HOLD);
    end
  end

  // Re-gating after the register lets a user disable cut the motor immediately.
  assign active  = active_r & gate;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rumble_ctrl.sv
module tb_rumble_ctrl;
  import rumble_pkg::*;

  logic       clk_74a = 1'b0;
  logic       reset = 1'b1;
  logic       motor_req = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] strength = 2'd3;
  logic       active, busy, timeout;

  int total = 0;
  int bad = 0;

  logic   act_log [0:199];
  logic   bsy_log [0:199];
  logic   tmo_log [0:199];
  state_t st_log  [0:199];

  rumble_ctrl #(
    .PRESCALE   (4),
    .DEBOUNCE_MS(2),
    .MIN_ON_MS  (5),
    .MAX_ON_MS  (20),
    .COOLDOWN_MS(8),
    .PWM_DIV    (1)
  ) dut (
    .clk_74a  (clk_74a),
    .reset    (reset),
    .motor_req(motor_req),
    .enable   (enable),
    .strength (strength),
    .active   (active),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk_74a = ~clk_74a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reset edge is R; on return we sit at the negedge after R (k=0).
  task automatic do_reset(input logic mreq, input logic [1:0] str);
    @(negedge clk_74a);
    reset = 1'b1;
    motor_req = mreq;
    strength = str;
    enable = 1'b1;
    @(negedge clk_74a);
    reset = 1'b0;
  endtask

  // Sample at the negedge after R+k, then apply any scheduled request change.
  task automatic capture(input int n, input int rise_k, input int drop_k);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_74a);
      act_log[k] = active;
      bsy_log[k] = busy;
      tmo_log[k] = timeout;
      st_log[k]  = dut.state;
      if (k == rise_k) motor_req = 1'b1;
      if (k == drop_k) motor_req = 1'b0;
    end
  endtask

  function automatic int first_high(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (act_log[k]) return k;
    return -1;
  endfunction

  function automatic int count_high(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (act_log[k]) c++;
    return c;
  endfunction

  task automatic test_reset_state();
    do_reset(1'b0, 2'd3);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE); end
  endtask

  task automatic test_reset();
    do_reset(1'b1, 2'd3);
    capture(15, -1, -1);
    total++; if (act_log[15] !== 1'b1) begin bad++; $display("FAIL midon_active got=%b want=1", act_log[15]); end
    do_reset(1'b1, 2'd3);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_midon_active got=%b want=0", active); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_midon_busy got=%b want=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_midon_timeout got=%b want=0", timeout); end
    capture(14, -1, -1);
    // 2 sync + 2 ticks (edge R+8) + FSM (R+9) + output register (R+10).
    total++; if (first_high(1, 14) != 10) begin bad++; $display("FAIL restart_latency got=%0d want=10", first_high(1, 14)); end
  endtask

  task automatic test_glitch();
    logic any_act, any_busy;
    do_reset(1'b0, 2'd3);
    capture(40, 5, 9);
    any_act = 1'b0;
    any_busy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      any_act  |= act_log[k];
      any_busy |= bsy_log[k];
    end
    total++; if (any_act !== 1'b0) begin bad++; $display("FAIL glitch_active got=%b want=0", any_act); end
    total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", any_busy); end
  endtask

  task automatic test_min_on();
    int last;
    do_reset(1'b1, 2'd3);
    capture(35, -1, 12);
    last = -1;
    for (int k = 1; k <= 35; k++) if (act_log[k]) last = k;
    total++; if (first_high(1, 35) != 10) begin bad++; $display("FAIL minon_rise got=%0d want=10", first_high(1, 35)); end
    total++; if (last != 28) begin bad++; $display("FAIL minon_last_high got=%0d want=28", last); end
    total++; if (st_log[20] !== ON) begin bad++; $display("FAIL minon_state20 got=%0d want=%0d", st_log[20], ON); end
    total++; if (st_log[21] !== HOLD) begin bad++; $display("FAIL minon_hold got=%0d want=%0d", st_log[21], HOLD); end
    total++; if (st_log[28] !== IDLE) begin bad++; $display("FAIL minon_idle got=%0d want=%0d", st_log[28], IDLE); end
    total++; if (bsy_log[29] !== 1'b0) begin bad++; $display("FAIL minon_busy_end got=%b want=0", bsy_log[29]); end
  endtask

  task automatic test_timeout();
    do_reset(1'b1, 2'd3);
    capture(130, -1, -1);
    total++; if (count_high(10, 88) != 79) begin bad++; $display("FAIL to_on_cycles got=%0d want=79", count_high(10, 88)); end
    total++; if (act_log[89] !== 1'b0) begin bad++; $display("FAIL to_active_off got=%b want=0", act_log[89]); end
    total++; if (tmo_log[87] !== 1'b0) begin bad++; $display("FAIL to_flag_early got=%b want=0", tmo_log[87]); end
    total++; if (tmo_log[88] !== 1'b1) begin bad++; $display("FAIL to_flag_set got=%b want=1", tmo_log[88]); end
    total++; if (count_high(89, 121) != 0) begin bad++; $display("FAIL to_cooldown_active got=%0d want=0", count_high(89, 121)); end
    total++; if (act_log[122] !== 1'b1) begin bad++; $display("FAIL to_reenter got=%b want=1", act_log[122]); end
    total++; if (tmo_log[130] !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", tmo_log[130]); end
  endtask

  // Runs straight on from test_timeout: state ON, timeout set, request held.
  task automatic test_disable_clears();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL dis_pre_active got=%b want=1", active); end
    enable = 1'b0;
    #1;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL dis_comb_gate got=%b want=0", active); end
    @(negedge clk_74a);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL dis_timeout got=%b want=0", timeout); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL dis_state got=%0d want=%0d", dut.state, IDLE); end
    enable = 1'b1;
    @(negedge clk_74a);
    total++; if (dut.state !== ON) begin bad++; $display("FAIL reen_state got=%0d want=%0d", dut.state, ON); end
    @(negedge clk_74a);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL reen_active got=%b want=1", active); end
  endtask

  task automatic test_pwm();
    do_reset(1'b1, 2'd1);
    capture(47, -1, -1);
    total++; if (count_high(32, 47) != 4) begin bad++; $display("FAIL pwm25_count got=%0d want=4", count_high(32, 47)); end
    total++; if (first_high(32, 47) != 33) begin bad++; $display("FAIL pwm25_phase got=%0d want=33", first_high(32, 47)); end
    do_reset(1'b1, 2'd2);
    capture(50, -1, -1);
    total++; if (count_high(32, 47) != 8) begin bad++; $display("FAIL pwm50_count got=%0d want=8", count_high(32, 47)); end
    total++; if (first_high(32, 47) != 33) begin bad++; $display("FAIL pwm50_phase got=%0d want=33", first_high(32, 47)); end
    total++; if (act_log[50] !== 1'b1) begin bad++; $display("FAIL pwm50_pre_off got=%b want=1", act_log[50]); end
    strength = 2'd0;
    #1;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL str0_comb_gate got=%b want=0", active); end
    @(negedge clk_74a);
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL str0_state got=%0d want=%0d", dut.state, IDLE); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL str0_active got=%b want=0", active); end
  endtask

  initial begin
    test_reset_state();
    test_reset();
    test_glitch();
    test_min_on();
    test_timeout();
    test_disable_clears();
    test_pwm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rumble_ctrl.md
Name: rumble_ctrl

Overview:
- Upstream neighbour of the cartridge-port rumble driver; produces the single `active` level that the driver turns into the cart enable and motor pulse.
- Takes the Pokemon Mini core's raw motor request, synchronises and debounces it, then applies user enable and strength (PWM) settings.
- Guarantees a minimum motor-on time, a maximum continuous on time, and a cooldown period before the motor can restart.

Parameters:
- PRESCALE, 74250, clk_74a cycles per ms tick (1 ms at 74.25 MHz).
- DEBOUNCE_MS, 2, ticks motor_req must be stable before it is accepted.
- MIN_ON_MS, 20, minimum ticks the motor stays on once started.
- MAX_ON_MS, 3000, maximum continuous on ticks before a forced cooldown.
- COOLDOWN_MS, 500, forced-off ticks after a timeout.
- PWM_DIV, 4640, clk_74a cycles per PWM step (16 steps per PWM frame).

Ports:
- clk_74a  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- motor_req  in  1  raw motor request from the core; asynchronous to clk_74a.
- enable  in  1  user rumble enable, already in the clk_74a domain.
- strength  in  2  user strength: 0=off, 1=25%, 2=50%, 3=100% duty.
- active  out  1  motor drive level to the rumble driver.
- busy  out  1  high in ON or HOLD.
- timeout  out  1  sticky flag; set on a MAX_ON_MS expiry, cleared by reset or when enable goes low.

Behaviour:
- One clock, clk_74a. Reset is synchronous and active-high; every register clears on the clk_74a edge that samples reset=1.
- Reset values: active=0, busy=0, timeout=0, state=IDLE, all counters 0, synchroniser 0.
- Synchroniser:
  - motor_req passes through a 2-flop synchroniser into req_s.
  - Debounce: req_f changes only after req_s has differed from req_f for DEBOUNCE_MS consecutive ticks; any bounce restarts the count.
- Tick: prescaler counts 0..PRESCALE-1. tick=1 for one cycle at wrap; the first tick comes PRESCALE cycles after reset.
- State machine: IDLE, ON, HOLD, COOLDOWN. Evaluated every cycle; counters advance only on tick.
  - IDLE: if req_f & enable & strength!=0, go to ON and clear on_cnt.
  - ON: on_cnt increments on tick.
    - If on_cnt reaches MAX_ON_MS: go to COOLDOWN, set timeout, clear cd_cnt.
    - Else if !req_f and on_cnt>=MIN_ON_MS: go to IDLE.
    - Else if !req_f: go to HOLD.
  - HOLD: on_cnt keeps counting. When on_cnt>=MIN_ON_MS go to IDLE. If req_f reasserts, return to ON without resetting on_cnt.
  - COOLDOWN: cd_cnt increments on tick; at COOLDOWN_MS go to IDLE. Requests are ignored.
  - From any state, enable=0 or strength=0 forces IDLE on the next cycle; active is 0 that same cycle (combinational gate) and timeout clears.
  - Simultaneous MAX_ON expiry and request drop: the timeout wins (COOLDOWN).
- PWM:
  - step counter advances every PWM_DIV cycles; pwm_pos is 4 bits and wraps 15 to 0.
  - Duty threshold: strength 1 gives 4/16, strength 2 gives 8/16, strength 3 gives always on.
  - pwm_on = (pwm_pos < threshold), forced to 1 when strength==3.
  - The PWM counter free-runs and is not reset on state entry.
- Output: active is registered = (state==ON or HOLD) & pwm_on & enable & strength!=0. The enable/strength term is also ANDed combinationally after the register so a disable takes effect in 0 cycles.
- busy is registered and follows state with 1 cycle latency.
- Latency from a clean motor_req rise to active rise (strength 3): 2 sync cycles + DEBOUNCE_MS ticks (tick-aligned) + 1 FSM cycle + 1 output register cycle.
- Counter widths: $clog2(MAX+1) per parameter. No wrap is possible because the FSM exits at the terminal counts.

Decomposition:
- Shared package rumble_pkg:
  - state enum (IDLE, ON, HOLD, COOLDOWN);
  - strength encoding constants;
  - duty threshold lookup function.
- One natural sub-module: rumble_debounce (2-flop synchroniser plus tick-based stable counter). It takes clk_74a, reset, tick, motor_req and returns req_f.
- The FSM, PWM and outputs stay in rumble_ctrl.

Test Plan:
- Bench parameters: PRESCALE=4, DEBOUNCE_MS=2, MIN_ON_MS=5, MAX_ON_MS=20, COOLDOWN_MS=8, PWM_DIV=1.
- Reset mid-ON with strength=3: assert reset for 1 cycle → next cycle active=0, busy=0, timeout=0; a held motor_req restarts via debounce (about 8 cycles or more) before active=1.
- Glitch rejection: motor_req high for 1 tick then low → active stays 0 and busy stays 0 throughout.
- Minimum on: motor_req high for 2 ticks after debounce, then low → active stays 1 until on_cnt=5 ticks (HOLD observed), then 0.
- Timeout: motor_req held high, strength=3 → active=1 for 20 ticks, then 0, timeout=1; active stays 0 for 8 ticks despite the request, then re-enters ON.
- PWM duty: strength=1, request held → active high exactly 4 of every 16 cycles. strength=2 → 8 of 16 cycles. strength=0 mid-ON → active=0 the same cycle and state goes to IDLE.
- Disable clears flag: after a timeout, enable=0 for 1 cycle → timeout=0 and state IDLE; re-enable with the request high → ON after 1 cycle.
